// File: rtl/prog_loader_pkg.sv
// Shared types and UART framing constants for the program loader.
// The checksum state only exists when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int words_per_byte(input int width);
        return UART_DATA_BITS / width;
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling,
// single-cycle byte_valid / frame_err pulses. Dropping i_enable aborts a byte.
module uart_byte_rx
    import prog_loader_pkg::*;
#(
    parameter int BAUD_COUNTS_PER_BIT        = 521,
    parameter int BAUD_RATE_COUNTER_BITWIDTH = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       i_enable,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int BW = BAUD_RATE_COUNTER_BITWIDTH;
    localparam int unsigned BIT_LAST  = BAUD_COUNTS_PER_BIT - 1;
    localparam int unsigned HALF_LAST = BAUD_COUNTS_PER_BIT / 2 - 1;
    localparam logic [BW-1:0] C_BIT_LAST  = BW'(BIT_LAST);
    localparam logic [BW-1:0] C_HALF_LAST = BW'(HALF_LAST);
    localparam logic [2:0]    C_LAST_BIT  = 3'(UART_DATA_BITS - 1);

    rx_state_t     r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_ferr;

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_ferr;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= RX_IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (!i_enable) begin
                r_state <= RX_IDLE;
                r_baud  <= '0;
                r_bit   <= '0;
            end else begin
                case (r_state)
                    RX_IDLE: begin
                        if (r_prev != UART_START_BIT && r_sync2 == UART_START_BIT) begin
                            r_baud  <= '0;
                            r_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        // A start bit that is gone by half-bit is treated as a glitch
                        if (r_baud == C_HALF_LAST) begin
                            r_baud  <= '0;
                            r_bit   <= '0;
                            r_state <= (r_sync2 == UART_START_BIT) ? RX_DATA : RX_IDLE;
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (r_baud == C_BIT_LAST) begin
                            r_baud <= '0;
                            r_byte <= {r_sync2, r_byte[7:1]};
                            r_bit  <= r_bit + 1'b1;
                            if (r_bit == C_LAST_BIT) begin
                                r_state <= RX_STOP;
                            end
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (r_baud == C_BIT_LAST) begin
                            r_baud  <= '0;
                            r_state <= RX_IDLE;
                            if (r_sync2 == UART_STOP_BIT) begin
                                r_valid <= 1'b1;
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end else begin
                            r_baud <= r_baud + 1'b1;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: header N, packed data words, optional checksum byte
// (PROG_LOADER_CHECKSUM_EN). Writes unpacked words to program memory.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int REGISTER_WIDTH             = 4,
    parameter int MEMORY_ADDRESS_WIDTH       = 4,
    parameter int MEMORY_REGISTERS           = 16,
    parameter int BAUD_COUNTS_PER_BIT        = 521,
    parameter int BAUD_RATE_COUNTER_BITWIDTH = 10
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            p_programm_i,
    input  logic                            rx_i,
    output logic                            we_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] waddr_o,
    output logic [REGISTER_WIDTH-1:0]       wdata_o,
    output logic                            cpu_hold_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int WPB = words_per_byte(REGISTER_WIDTH);
    localparam int CW  = (MEMORY_ADDRESS_WIDTH + 1 > 9) ? MEMORY_ADDRESS_WIDTH + 1 : 9;
    localparam logic [CW-1:0] MAX_N = CW'(MEMORY_REGISTERS);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;

    state_t                          r_state;
    logic [CW-1:0]                   r_count;
    logic [CW-1:0]                   r_addr;
    logic [7:0]                      r_bytes_left;
    logic [7:0]                      r_shift;
    logic [1:0]                      r_words_left;
    logic                            r_we;
    logic [MEMORY_ADDRESS_WIDTH-1:0] r_waddr;
    logic [REGISTER_WIDTH-1:0]       r_wdata;
    logic                            r_hold;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]                      r_sum;
`endif

    uart_byte_rx #(
        .BAUD_COUNTS_PER_BIT        (BAUD_COUNTS_PER_BIT),
        .BAUD_RATE_COUNTER_BITWIDTH (BAUD_RATE_COUNTER_BITWIDTH)
    ) u_rx (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .i_enable     (p_programm_i),
        .i_rx         (rx_i),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign we_o       = r_we;
    assign waddr_o    = r_waddr;
    assign wdata_o    = r_wdata;
    assign cpu_hold_o = r_hold;
    assign done_o     = (r_state == ST_DONE);
    assign err_o      = (r_state == ST_ERROR);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign busy_o     = (r_state == ST_HEADER) || (r_state == ST_DATA) || (r_state == ST_CHECK);
`else
    assign busy_o     = (r_state == ST_HEADER) || (r_state == ST_DATA);
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_addr       <= '0;
            r_bytes_left <= '0;
            r_shift      <= '0;
            r_words_left <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_hold       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_hold <= p_programm_i;
            if (!p_programm_i) begin
                r_state      <= ST_IDLE;
                r_words_left <= '0;
            end else begin
                // Trailing words of a byte drain one per cycle; words past N are dropped
                if (r_words_left != '0) begin
                    r_words_left <= r_words_left - 1'b1;
                    r_shift      <= r_shift << REGISTER_WIDTH;
                    if (r_addr < r_count) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr[MEMORY_ADDRESS_WIDTH-1:0];
                        r_wdata <= r_shift[7 -: REGISTER_WIDTH];
                        r_addr  <= r_addr + 1'b1;
                    end
                end
                case (r_state)
                    ST_IDLE: r_state <= ST_HEADER;
                    ST_HEADER: begin
                        if (w_frame_err) begin
                            r_state <= ST_ERROR;
                        end else if (w_byte_valid) begin
                            if (w_byte == 8'd0 || CW'(w_byte) > MAX_N) begin
                                r_state <= ST_ERROR;
                            end else begin
                                r_count      <= CW'(w_byte);
                                r_addr       <= '0;
                                r_bytes_left <= (WPB == 1) ? w_byte : 8'((9'(w_byte) + 9'd1) >> 1);
`ifdef PROG_LOADER_CHECKSUM_EN
                                r_sum        <= '0;
`endif
                                r_state      <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_frame_err) begin
                            r_state <= ST_ERROR;
                        end else if (w_byte_valid) begin
                            r_bytes_left <= r_bytes_left - 1'b1;
                            r_shift      <= w_byte << REGISTER_WIDTH;
                            r_words_left <= 2'(WPB - 1);
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_sum        <= r_sum + w_byte;
`endif
                            if (r_addr < r_count) begin
                                r_we    <= 1'b1;
                                r_waddr <= r_addr[MEMORY_ADDRESS_WIDTH-1:0];
                                r_wdata <= w_byte[7 -: REGISTER_WIDTH];
                                r_addr  <= r_addr + 1'b1;
                            end
                        end else if (r_bytes_left == '0 && r_words_left == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_DONE;
`endif
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        if (w_frame_err) begin
                            r_state <= ST_ERROR;
                        end else if (w_byte_valid) begin
                            r_state <= (w_byte == r_sum) ? ST_DONE : ST_ERROR;
                        end
                    end
`endif
                    ST_DONE:  r_state <= ST_DONE;
                    ST_ERROR: r_state <= ST_ERROR;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
